// File: rtl/commonlib_stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   calc_sw()    : select width for an N-lane demux, max(1, ceil(log2(N)))
//   DROP_W       : width of the saturating dropped-beat counter
//   slot_state_e : occupancy of the single-beat holding register
package commonlib_stream_demux_pkg;

  localparam int DROP_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  function automatic int calc_sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/commonlib_stream_demux_slot.sv
// Single-beat holding register for the stream demux.
// Ports:
//   CLK, ASYNCRESET     : clock, asynchronous active-high reset
//   in_data/in_sel      : incoming beat payload and destination lane
//   in_valid/in_ready   : input handshake; in_ready depends only on state
//                         and out_ready, never on the input side
//   out_ready[N]        : per-lane ready; only the held lane's bit matters
//   full                : a beat is held
//   held_data/held_sel  : the held beat
//   in_drop             : pulse when an out-of-range beat is accepted
module commonlib_stream_demux_slot
  import commonlib_stream_demux_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int SW    = calc_sw(N)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     out_ready,
  output logic             full,
  output logic [WIDTH-1:0] held_data,
  output logic [SW-1:0]    held_sel,
  output logic             in_drop
);

  localparam logic [SW:0] N_EXT = (SW + 1)'(N);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    sel_q, sel_d;

  logic lane_rdy;
  logic in_xfer;
  logic in_ok;
  logic lane_xfer;

  // Ready of the currently held lane; a loop avoids indexing past N when
  // SW can encode more lanes than exist.
  always_comb begin
    lane_rdy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_q == SW'(k)) lane_rdy = out_ready[k];
    end
  end

  assign in_ready  = (state_q == ST_EMPTY) || lane_rdy;
  assign in_xfer   = in_valid && in_ready;
  assign in_ok     = ({1'b0, in_sel} < N_EXT);
  assign lane_xfer = (state_q == ST_FULL) && lane_rdy;
  assign in_drop   = in_xfer && !in_ok;

  // A new in-range beat always wins: when FULL it can only be accepted
  // alongside a drain, so it replaces the old beat with no bubble.
  // Otherwise a drain empties the slot, including the case where the
  // accepted beat was out of range and discarded.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (in_xfer && in_ok) begin
      state_d = ST_FULL;
      data_d  = in_data;
      sel_d   = in_sel;
    end else if (lane_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign full      = (state_q == ST_FULL);
  assign held_data = data_q;
  assign held_sel  = sel_q;

endmodule

// File: rtl/commonlib_stream_demux.sv
// One-to-N stream demultiplexer with a single-beat holding register.
// A beat accepted on the input appears on lane in_sel the next cycle.
// Beats with in_sel >= N are accepted, discarded and counted.
// Ports:
//   CLK, ASYNCRESET      : clock, asynchronous active-high reset
//   in_data/in_sel       : input beat and destination lane index
//   in_valid/in_ready    : input handshake
//   out_data[N*WIDTH]    : lane k at [k*WIDTH +: WIDTH]; all lanes carry
//                          the held payload
//   out_valid/out_ready  : per-lane handshake
//   drop_count           : saturating count of out-of-range beats
module commonlib_stream_demux
  import commonlib_stream_demux_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  localparam int SW   = calc_sw(N)
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SW-1:0]      in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [DROP_W-1:0]  drop_count
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             full;
  logic [WIDTH-1:0] held_data;
  logic [SW-1:0]    held_sel;
  logic             in_drop;

  logic [DROP_W-1:0] drop_q, drop_d;

  commonlib_stream_demux_slot #(
    .N     (N),
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_slot (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .full       (full),
    .held_data  (held_data),
    .held_sel   (held_sel),
    .in_drop    (in_drop)
  );

  // Lane decode: one-hot valid on the held lane only.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N; k++) begin
      out_valid[k] = full && (held_sel == SW'(k));
    end
  end

  assign out_data = {N{held_data}};

  always_comb begin
    drop_d = drop_q;
    if (in_drop) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) drop_q <= '0;
    else            drop_q <= drop_d;
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_commonlib_stream_demux.sv
module tb_commonlib_stream_demux;

  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int SW    = 2;

  logic               CLK = 1'b0;
  logic               ASYNCRESET;
  logic [WIDTH-1:0]   in_data;
  logic [SW-1:0]      in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [7:0]         drop_count;

  int n_chk  = 0;
  int n_pass = 0;

  commonlib_stream_demux #(.N(N), .WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] lane(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    ASYNCRESET = 1'b1;
    in_data    = '0;
    in_sel     = '0;
    in_valid   = 1'b0;
    out_ready  = 3'b111;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_drop", 64'(drop_count), 64'h0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // Basic routing
    in_data = 8'hA5; in_sel = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("route_valid", 64'(out_valid), 64'h2);
    chk("route_data", 64'(lane(1)), 64'hA5);
    tick();
    chk("route_empty", 64'(out_valid), 64'h0);

    // Back-pressure with a waiting beat that must not be accepted early
    in_data = 8'h3C; in_sel = 2'd2; in_valid = 1'b1; out_ready = 3'b011;
    tick();
    in_data = 8'h77; in_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'h4);
      chk("bp_data", 64'(lane(2)), 64'h3C);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      tick();
    end
    out_ready = 3'b111;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", 64'(out_valid), 64'h1);
    chk("bp_next_data", 64'(lane(0)), 64'h77);
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);

    // Full throughput, sel cycling 0,1,2
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i); in_sel = 2'((i - 1) % 3); in_valid = 1'b1;
      tick();
      chk("thr_valid", 64'(out_valid), 64'(1 << ((i - 1) % 3)));
      chk("thr_data", 64'(lane((i - 1) % 3)), 64'(i));
      chk("thr_in_ready", 64'(in_ready), 64'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("thr_empty", 64'(out_valid), 64'h0);

    // Drops saturate
    in_data = 8'hEE; in_sel = 2'd3; in_valid = 1'b1;
    tick();
    chk("drop_first", 64'(drop_count), 64'h1);
    chk("drop_first_valid", 64'(out_valid), 64'h0);
    for (int i = 1; i < 300; i++) tick();
    chk("drop_sat", 64'(drop_count), 64'd255);
    chk("drop_sat_valid", 64'(out_valid), 64'h0);
    in_data = 8'h5A; in_sel = 2'd0;
    tick();
    in_valid = 1'b0;
    chk("drop_after_valid", 64'(out_valid), 64'h1);
    chk("drop_after_data", 64'(lane(0)), 64'h5A);
    chk("drop_after_cnt", 64'(drop_count), 64'd255);
    tick();

    // Reset mid-operation while FULL
    in_data = 8'h99; in_sel = 2'd2; in_valid = 1'b1; out_ready = 3'b000;
    tick();
    in_valid = 1'b0;
    chk("mid_full_valid", 64'(out_valid), 64'h4);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_drop", 64'(drop_count), 64'h0);
    chk("mid_rst_ready", 64'(in_ready), 64'h1);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    out_ready = 3'b111;
    tick();
    chk("mid_gone_1", 64'(out_valid), 64'h0);
    tick();
    chk("mid_gone_2", 64'(out_valid), 64'h0);

    // Simultaneous drop and drain
    in_data = 8'h11; in_sel = 2'd0; in_valid = 1'b1;
    tick();
    chk("dd_full", 64'(out_valid), 64'h1);
    in_data = 8'h22; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("dd_empty", 64'(out_valid), 64'h0);
    chk("dd_drop", 64'(drop_count), 64'h1);
    tick();
    chk("dd_stay_empty", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
